// File: rtl/stage_id_pkg.sv
// rtl/stage_id_pkg.sv - shared encodings for the ARM instruction decode stage
package stage_id_pkg;

  localparam int NUM_REGS = 15;
  localparam int DATA_W   = 32;

  // ALU command encodings handed to EXE
  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_MVN  = 4'b1001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_MEM = 4'b0100;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c & !z;
      COND_LS: cond_pass = !c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage_id_register_file.sv
// rtl/stage_id_register_file.sv - R0..R14 register file, one write port, two bypassed read ports
module stage_id_register_file
  import stage_id_pkg::*;
#(
  parameter int NUM_REGS = stage_id_pkg::NUM_REGS,
  parameter int DATA_W   = stage_id_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [3:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en && (wr_addr < 4'(NUM_REGS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i);
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // R15 (the PC) is not stored here and reads back as zero
  function automatic logic [DATA_W-1:0] rd(input logic [3:0] addr);
    if (addr >= 4'(NUM_REGS))             rd = '0;
    else if (wr_en && (wr_addr == addr))  rd = wr_data;
    else                                  rd = regs[addr];
  endfunction

  assign rd_data1 = rd(rd_addr1);
  assign rd_data2 = rd(rd_addr2);

endmodule

// File: rtl/stage_id.sv
// rtl/stage_id.sv - ARM pipeline instruction decode stage ending in the ID/EXE register
module stage_id
  import stage_id_pkg::*;
#(
  parameter int NUM_REGS = stage_id_pkg::NUM_REGS,
  parameter int DATA_W   = stage_id_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction_in,
  input  logic [3:0]        status_in,
  input  logic              wb_en_in,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic              mem_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic [3:0]        mem_dest,
  output logic              hazard,
  output logic [DATA_W-1:0] pc_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out
);

  logic [3:0]  cond, opcode, rn, rd, rm;
  logic [1:0]  mode;
  logic        i_bit, s_bit;
  logic [11:0] shift_operand;
  logic [23:0] imm24;

  assign cond          = instruction_in[31:28];
  assign mode          = instruction_in[27:26];
  assign i_bit         = instruction_in[25];
  assign opcode        = instruction_in[24:21];
  assign s_bit         = instruction_in[20];
  assign rn            = instruction_in[19:16];
  assign rd            = instruction_in[15:12];
  assign shift_operand = instruction_in[11:0];
  assign rm            = instruction_in[3:0];
  assign imm24         = instruction_in[23:0];

  logic       dec_wb_en, dec_mem_r, dec_mem_w, dec_b, dec_s;
  logic [3:0] dec_cmd;
  logic       is_nop, is_str, rn_used;

  always_comb begin
    dec_wb_en = 1'b0;
    dec_mem_r = 1'b0;
    dec_mem_w = 1'b0;
    dec_b     = 1'b0;
    dec_s     = 1'b0;
    dec_cmd   = EXE_NONE;
    is_nop    = 1'b0;
    is_str    = 1'b0;
    rn_used   = 1'b1;
    case (mode)
      MODE_DP: begin
        dec_wb_en = 1'b1;
        dec_s     = s_bit;
        case (opcode)
          OP_MOV: begin dec_cmd = EXE_MOV; rn_used = 1'b0; end
          OP_MVN: begin dec_cmd = EXE_MVN; rn_used = 1'b0; end
          OP_ADD: dec_cmd = EXE_ADD;
          OP_ADC: dec_cmd = EXE_ADC;
          OP_SUB: dec_cmd = EXE_SUB;
          OP_SBC: dec_cmd = EXE_SBC;
          OP_AND: dec_cmd = EXE_AND;
          OP_ORR: dec_cmd = EXE_ORR;
          OP_EOR: dec_cmd = EXE_EOR;
          OP_CMP: begin dec_cmd = EXE_SUB; dec_wb_en = 1'b0; dec_s = 1'b1; end
          OP_TST: begin dec_cmd = EXE_AND; dec_wb_en = 1'b0; dec_s = 1'b1; end
          default: begin
            dec_wb_en = 1'b0;
            dec_s     = 1'b0;
            is_nop    = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        if (opcode == OP_MEM) begin
          dec_cmd = EXE_ADD;
          if (s_bit) begin
            dec_mem_r = 1'b1;
            dec_wb_en = 1'b1;
          end else begin
            dec_mem_w = 1'b1;
            is_str    = 1'b1;
          end
        end else begin
          is_nop = 1'b1;
        end
      end
      MODE_BR: begin
        dec_b   = 1'b1;
        rn_used = 1'b0;
      end
      default: is_nop = 1'b1;
    endcase
  end

  logic [3:0]        src1, src2;
  logic              two_src;
  logic [DATA_W-1:0] val_rn, val_rm;

  assign src1    = rn;
  assign src2    = is_str ? rd : rm;
  assign two_src = ((mode == MODE_DP) && !i_bit) || is_str;

  stage_id_register_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wb_en_in),
    .wr_addr  (wb_dest),
    .wr_data  (wb_value),
    .rd_addr1 (src1),
    .rd_data1 (val_rn),
    .rd_addr2 (src2),
    .rd_data2 (val_rm)
  );

  // RAW against the producers still in EXE and MEM; NOPs and branches read nothing
  logic haz_exe, haz_mem, bubble;

  assign haz_exe = exe_wb_en && ((rn_used && (exe_dest == src1)) || (two_src && (exe_dest == src2)));
  assign haz_mem = mem_wb_en && ((rn_used && (mem_dest == src1)) || (two_src && (mem_dest == src2)));
  assign hazard  = !is_nop && !dec_b && (haz_exe || haz_mem);
  assign bubble  = hazard || !cond_pass(cond, status_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out            <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
    end else if (flush) begin
      pc_out            <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
    end else begin
      // a bubble only kills the side effects; operand fields still travel
      pc_out            <= pc_in;
      wb_en_out         <= bubble ? 1'b0 : dec_wb_en;
      mem_r_en_out      <= bubble ? 1'b0 : dec_mem_r;
      mem_w_en_out      <= bubble ? 1'b0 : dec_mem_w;
      b_out             <= bubble ? 1'b0 : dec_b;
      s_out             <= bubble ? 1'b0 : dec_s;
      exe_cmd_out       <= bubble ? EXE_NONE : dec_cmd;
      val_rn_out        <= val_rn;
      val_rm_out        <= val_rm;
      imm_out           <= i_bit;
      shift_operand_out <= shift_operand;
      signed_imm24_out  <= imm24;
      dest_out          <= rd;
      src1_out          <= src1;
      src2_out          <= src2;
    end
  end

endmodule

// File: tb/tb_stage_id.sv
// tb/tb_stage_id.sv - directed self-checking bench for stage_id
module tb_stage_id;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc_in, instruction_in, wb_value;
  logic [3:0]  status_in, wb_dest, exe_dest, mem_dest;
  logic        wb_en_in, exe_wb_en, mem_wb_en;
  logic        hazard, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;

  int checks = 0;
  int failures = 0;

  stage_id dut (
    .clk(clk), .rst(rst), .flush(flush), .pc_in(pc_in), .instruction_in(instruction_in),
    .status_in(status_in), .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .hazard(hazard), .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    flush = $urandom_range(0, 1);
    pc_in = $urandom;
    instruction_in = $urandom;
    status_in = 4'($urandom);
    wb_en_in = $urandom_range(0, 1);
    wb_dest = 4'($urandom);
    wb_value = $urandom;
    exe_wb_en = $urandom_range(0, 1);
    mem_wb_en = $urandom_range(0, 1);
    exe_dest = 4'($urandom);
    mem_dest = 4'($urandom);
    tick();
    tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_wb_en", {31'b0, wb_en_out}, 32'h0);
    check("rst_b", {31'b0, b_out}, 32'h0);
    check("rst_val_rn", val_rn_out, 32'h0);
    check("rst_imm24", {8'b0, signed_imm24_out}, 32'h0);

    flush = 1'b0; pc_in = 32'h100; status_in = 4'b0000;
    wb_en_in = 1'b0; wb_dest = 4'd0; wb_value = 32'h0;
    exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_dest = 4'd0; mem_dest = 4'd0;
    instruction_in = 32'hE0850006;      // ADD R0,R5,R6
    rst = 1'b1;
    tick();
    check("reset_r5", val_rn_out, 32'd5);
    check("reset_r6", val_rm_out, 32'd6);
    check("reset_pc", pc_out, 32'h100);

    instruction_in = 32'hE0821003;      // ADD R1,R2,R3
    check("add_hazard", {31'b0, hazard}, 32'h0);
    tick();
    check("add_cmd", {28'b0, exe_cmd_out}, 32'h2);
    check("add_wb_en", {31'b0, wb_en_out}, 32'h1);
    check("add_rn", val_rn_out, 32'd2);
    check("add_rm", val_rm_out, 32'd3);
    check("add_dest", {28'b0, dest_out}, 32'd1);

    wb_en_in = 1'b1; wb_dest = 4'd2; wb_value = 32'hDEAD;
    tick();
    check("wt_rn", val_rn_out, 32'hDEAD);
    wb_en_in = 1'b0;
    tick();
    check("wt_stored", val_rn_out, 32'hDEAD);

    wb_en_in = 1'b1; wb_dest = 4'd15; wb_value = 32'h1234;
    instruction_in = 32'hE08F100F;      // ADD R1,R15,R15
    tick();
    check("r15_rn", val_rn_out, 32'h0);
    wb_en_in = 1'b0;

    instruction_in = 32'hE0821003;
    exe_wb_en = 1'b1; exe_dest = 4'd2;
    #1 check("haz_exe_rn", {31'b0, hazard}, 32'h1);
    tick();
    check("haz_wb_en", {31'b0, wb_en_out}, 32'h0);
    check("haz_cmd", {28'b0, exe_cmd_out}, 32'h0);
    check("haz_dest", {28'b0, dest_out}, 32'd1);

    instruction_in = 32'hE3A01005;      // MOV R1,#5
    #1 check("mov_no_haz", {31'b0, hazard}, 32'h0);
    tick();
    check("mov_cmd", {28'b0, exe_cmd_out}, 32'h1);
    check("mov_imm", {31'b0, imm_out}, 32'h1);
    check("mov_shop", {20'b0, shift_operand_out}, 32'h005);
    exe_wb_en = 1'b0;

    mem_wb_en = 1'b1; mem_dest = 4'd4;
    instruction_in = 32'hE4824000;      // STR R4,[R2]
    #1 check("str_haz_rd", {31'b0, hazard}, 32'h1);
    mem_dest = 4'd7;
    #1 check("str_no_haz", {31'b0, hazard}, 32'h0);
    tick();
    check("str_mem_w", {31'b0, mem_w_en_out}, 32'h1);
    check("str_wb_en", {31'b0, wb_en_out}, 32'h0);
    check("str_rm", val_rm_out, 32'd4);
    check("str_src2", {28'b0, src2_out}, 32'd4);
    mem_wb_en = 1'b0;

    instruction_in = 32'hE4924008;      // LDR R4,[R2,#8]
    tick();
    check("ldr_mem_r", {31'b0, mem_r_en_out}, 32'h1);
    check("ldr_cmd", {28'b0, exe_cmd_out}, 32'h2);

    instruction_in = 32'hE1520003;      // CMP R2,R3
    tick();
    check("cmp_wb_en", {31'b0, wb_en_out}, 32'h0);
    check("cmp_s", {31'b0, s_out}, 32'h1);
    check("cmp_cmd", {28'b0, exe_cmd_out}, 32'h4);

    instruction_in = 32'h00821003;      // ADDEQ R1,R2,R3
    status_in = 4'b0000;
    tick();
    check("eq_fail_wb", {31'b0, wb_en_out}, 32'h0);
    check("eq_fail_cmd", {28'b0, exe_cmd_out}, 32'h0);
    status_in = 4'b0100;
    tick();
    check("eq_pass_wb", {31'b0, wb_en_out}, 32'h1);
    check("eq_pass_cmd", {28'b0, exe_cmd_out}, 32'h2);

    instruction_in = 32'hF0821003;      // cond 1111 never executes
    tick();
    check("nv_wb", {31'b0, wb_en_out}, 32'h0);

    instruction_in = 32'hEA000010;      // B +0x10
    exe_wb_en = 1'b1; exe_dest = 4'd0;
    pc_in = 32'h200;
    flush = 1'b1;
    #1 check("br_no_haz", {31'b0, hazard}, 32'h0);
    tick();
    check("flush_b", {31'b0, b_out}, 32'h0);
    check("flush_imm24", {8'b0, signed_imm24_out}, 32'h0);
    check("flush_pc", pc_out, 32'h0);
    flush = 1'b0;
    tick();
    check("br_b", {31'b0, b_out}, 32'h1);
    check("br_imm24", {8'b0, signed_imm24_out}, 32'h10);
    check("br_pc", pc_out, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
